// File: rtl/shift_right_iterative.sv
// -----------------------------------------------------------------------------
// shift_right_iterative
//   Iterative right shifter: one bit per clock. An operand is accepted in IDLE,
//   shifted shamt times in SHIFT, then held in DONE until the consumer takes it.
//
//   Optional feature macro: SHIFT_RIGHT_ARITH_EN
//     defined   -> arith=1 selects sign-fill (arithmetic shift)
//     undefined -> arith is ignored, every shift is logical (zero-fill)
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  operand present on in/shamt/arith
//   in_ready   out  1  high only in IDLE
//   in         in   N  value to shift right
//   shamt      in   5  shift amount 0..31
//   arith      in   1  1 = sign-fill, 0 = zero-fill
//   out_valid  out  1  high only in DONE
//   out_ready  in   1  consumer accepts the result
//   out        out  N  shifted result (retained after the handshake)
// -----------------------------------------------------------------------------
module shift_right_iterative #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in,
   input  logic [4:0]   shamt,
   input  logic         arith,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t       r_state;
   state_t       w_next;
   logic [N-1:0] r_data;
   logic [4:0]   r_cnt;
   logic         w_accept;
   logic         w_fill;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next state and handshake outputs
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      w_accept  = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_accept = 1'b1;
               w_next   = (shamt == 5'd0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Last shift happens on the edge where cnt goes 1 -> 0
            if (r_cnt == 5'd1) w_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

`ifdef SHIFT_RIGHT_ARITH_EN
   logic r_mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_mode <= 1'b0;
      else if (w_accept) r_mode <= arith;
   end

   assign w_fill = r_mode & r_data[N-1];
`else
   // arith has no effect in this build; the fill bit is constant zero
   logic w_unused_arith;
   assign w_unused_arith = arith;
   assign w_fill         = 1'b0;
`endif

   // Working register and down-counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_data <= in;
         r_cnt  <= shamt;
      end else if (r_state == SHIFT) begin
         r_data <= {w_fill, r_data[N-1:1]};
         r_cnt  <= r_cnt - 5'd1;
      end
   end

   assign out = r_data;

endmodule

// File: doc/shift_right_iterative.md
SHIFT_RIGHT_ITERATIVE -- requirements
Module: shift_right_iterative

Interface
REQ-001 Parameter N, default 32, data width; only N=32 is supported, and shamt width is log2(N)=5.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid  input  1  operand present on in/shamt/arith.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in  input  N  value to shift right.
REQ-007 shamt  input  5  shift amount, unsigned 0..31.
REQ-008 arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill).
REQ-009 out_valid  output  1  result available on out.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out  output  N  shifted result.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-013 Accept SHALL occur on an edge with state IDLE and in_valid=1; that edge captures in into the working register, shamt into the down-counter cnt, and arith into a mode flag.
REQ-014 On accept, next state SHALL be DONE if shamt=0, otherwise SHIFT.
REQ-015 In SHIFT, each edge SHALL shift the working register right by exactly 1 bit and decrement cnt; fill bit = register MSB if mode=1, else 0.
REQ-016 SHIFT SHALL go to DONE on the edge where cnt goes from 1 to 0.
REQ-017 out_valid SHALL rise exactly shamt edges after the accept edge; for shamt=0 it is high in the cycle immediately after the accept edge.
REQ-018 In DONE, out and out_valid SHALL hold stable until an edge with out_ready=1, which moves the state to IDLE.
REQ-019 in_valid, in, shamt and arith SHALL be ignored outside IDLE; there is no overlap of operations.
REQ-020 out SHALL equal in >> shamt (logical) or in >>> shamt (arithmetic) with N-bit truncation; no bits wrap around.
REQ-021 out SHALL retain the last result after DONE→IDLE until the next result is produced, though its value is only defined while out_valid=1.

Reset
REQ-022 While rst=1, state SHALL be IDLE, with cnt=0, the working register/out=0, out_valid=0, mode=0 and in_ready=1, effective immediately without waiting for a clock.
REQ-023 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; the first accept is possible on the first edge after rst deasserts.

Configuration
REQ-024 Macro SHIFT_RIGHT_ARITH_EN: when defined, the arith input selects sign-fill per REQ-015.
REQ-025 When SHIFT_RIGHT_ARITH_EN is undefined, arith SHALL be ignored, the mode flag tied to 0, all shifts logical, and no sign-fill logic synthesized.

Verification
REQ-026 Logical shift: in=0x8000_0000, shamt=31, arith=0, out_ready=1 -> out=0x0000_0001; out_valid rises 31 edges after accept, and in_ready returns 1 one edge later.
REQ-027 Arithmetic shift: in=0x8000_0000, shamt=31, arith=1 -> out=0xFFFF_FFFF with SHIFT_RIGHT_ARITH_EN defined; out=0x0000_0001 without it.
REQ-028 Zero shift: in=0xDEAD_BEEF, shamt=0 -> out=0xDEAD_BEEF with out_valid high in the cycle after the accept edge; also in=0x0000_00F0, shamt=4, arith=1 -> 0x0000_000F.
REQ-029 Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new data -> out, out_valid=1 and in_ready=0 stay constant and the new data is not accepted; out_ready=1 -> IDLE on the next edge.
REQ-030 Reset mid-shift: shamt=20, pulse rst asynchronously 10 edges after accept -> out_valid=0, out=0 and in_ready=1 without a clock edge; a new operand is accepted normally after release.
